// File: rtl/mmcm_drp_ctrl.sv
// mmcm_drp_ctrl: masked DRP read-modify-write of one MMCM register with reset hold and re-lock wait
module mmcm_drp_ctrl #(
    parameter int RST_HOLD     = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [6:0]  req_addr,
    input  logic [15:0] req_data,
    input  logic [15:0] req_mask,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);
    localparam int CMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ?
                          ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD) :
                          ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_RELEASE, S_LOCK_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d, rst_q, rst_d;
    logic [6:0]    addr_q, addr_d;
    logic [15:0]   data_q, data_d, mask_q, mask_d, di_q, di_d;
    logic [1:0]    lock_q;

    // LOCKED is asynchronous to DCLK, so bring it in through two flops
    always_ff @(posedge clk or posedge reset)
        if (reset) lock_q <= '0;
        else       lock_q <= {lock_q[0], mmcm_locked};

    // state, counter and output registers
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rst_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rst_q   <= rst_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            di_q    <= di_d;
        end

    // sequencing: cnt counts cycles since entering a timed state, so pulses land exactly on the limit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rst_d   = rst_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        di_d    = di_q;
        case (state_q)
            S_IDLE: if (req) begin
                state_d = S_HOLD;
                busy_d  = 1'b1;
                rst_d   = 1'b1;
                cnt_d   = CW'(1);
                addr_d  = req_addr;
                data_d  = req_data;
                mask_d  = req_mask;
            end
            S_HOLD: if (cnt_q == CW'(RST_HOLD)) state_d = S_RD_REQ;
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
                cnt_d   = CW'(1);
            end
            S_RD_WAIT, S_WR_WAIT: if (drp_drdy) begin
                state_d = (state_q == S_RD_WAIT) ? S_WR_REQ : S_RELEASE;
                di_d    = (state_q == S_RD_WAIT) ? ((drp_do & mask_q) | (data_q & ~mask_q)) : di_q;
            end else if (cnt_q == CW'(DRDY_TIMEOUT - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                busy_d  = 1'b0;
                rst_d   = 1'b0;
            end
            S_WR_REQ: begin
                state_d = S_WR_WAIT;
                cnt_d   = CW'(1);
            end
            S_RELEASE: begin
                state_d = S_LOCK_WAIT;
                rst_d   = 1'b0;
                cnt_d   = '0;
            end
            S_LOCK_WAIT: if (lock_q[1] || cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                state_d = S_IDLE;
                done_d  = lock_q[1];
                err_d   = !lock_q[1];
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mmcm_rst  = rst_q;
    assign drp_den   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign drp_dwe   = (state_q == S_WR_REQ);
    assign drp_daddr = addr_q;
    assign drp_di    = di_q;
endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// tb_mmcm_drp_ctrl: directed checks of the MMCM DRP read-modify-write controller
module tb_mmcm_drp_ctrl;
    localparam int RH = 4, DT = 16, LT = 40;

    logic        clk = 0, reset = 1, req = 0;
    logic [6:0]  req_addr = '0;
    logic [15:0] req_data = '0, req_mask = '0;
    logic        busy, done, err, drp_den, drp_dwe, mmcm_rst;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 0, mmcm_locked = 0;

    mmcm_drp_ctrl #(.RST_HOLD(RH), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .req_mask(req_mask), .busy(busy), .done(done), .err(err), .drp_den(drp_den),
        .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do),
        .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem [128];
    bit   drop_rd = 0, lock_en = 1;
    int   spur_req = 0, spur_ack = 0, pend = 0, lk = 0;
    logic prev_rst = 0;
    int   rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, rst_bad = 0;
    int   rd_cyc = 0, wr_cyc = 0, done_cyc = 0, err_cyc = 0, rel_cyc = 0;
    logic [6:0]  rd_addr = '0, wr_addr = '0;
    logic [15:0] wr_di = '0;
    logic        rd_busy = 0;

    // bus monitor, DRP responder (3-cycle latency) and MMCM lock model (locks 5 cycles after release)
    always @(negedge clk) begin
        if (drp_den && !drp_dwe) begin rd_cnt++; rd_cyc = cyc; rd_addr = drp_daddr; rd_busy = busy; end
        if (drp_den && drp_dwe) begin wr_cnt++; wr_cyc = cyc; wr_addr = drp_daddr; wr_di = drp_di; end
        if (drp_den && !mmcm_rst) rst_bad++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) begin err_cnt++; err_cyc = cyc; end
        if (done && err) both_cnt++;
        if (prev_rst && !mmcm_rst) rel_cyc = cyc;
        prev_rst = mmcm_rst;
        drp_drdy = 0;
        if (pend > 0) begin pend--; if (pend == 0) drp_drdy = 1; end
        if (spur_req != spur_ack) begin drp_drdy = 1; spur_ack = spur_req; end
        if (drp_den && !(drop_rd && !drp_dwe)) begin pend = 3; drp_do = drp_dwe ? 16'h0 : mem[drp_daddr]; end
        if (mmcm_rst) begin mmcm_locked = 0; lk = 0; end
        else if (lock_en && !mmcm_locked) begin lk++; if (lk >= 5) mmcm_locked = 1; end
    end

    int n_checks = 0, n_errors = 0;
    int b_rd, b_wr, b_done, b_err, a_cyc, a1_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_rd = rd_cnt; b_wr = wr_cnt; b_done = done_cnt; b_err = err_cnt;
    endtask

    task automatic go(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m);
        @(negedge clk);
        req = 1; req_addr = a; req_data = d; req_mask = m; a_cyc = cyc;
        @(negedge clk);
        req = 0;
    endtask

    task automatic wait_ev(input string tag, input int lim, input int n);
        int i = 0;
        while (i < lim && (done_cnt - b_done) + (err_cnt - b_err) < n) begin
            @(posedge clk);
            i++;
        end
        check(tag, 32'((done_cnt - b_done) + (err_cnt - b_err) >= n), 1);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        #3 check("rst_outs", {3'b0, busy, done, err, drp_den, drp_dwe, mmcm_rst, drp_daddr, drp_di}, 0);
        repeat (2) @(negedge clk);
        reset = 0;

        // 1: basic read-modify-write
        mem[8] = 16'hA5A5;
        snap(); go(7'h08, 16'h1041, 16'hF000); wait_ev("t1_wait", 200, 1); settle();
        check("t1_rd_lat", 32'(rd_cyc - a_cyc), RH + 1);
        check("t1_rd_addr", 32'(rd_addr), 32'h08);
        check("t1_rd_busy", 32'(rd_busy), 1);
        check("t1_wr_cyc", 32'(wr_cyc - a_cyc), RH + 5);
        check("t1_wr_di", 32'(wr_di), 32'hA041);
        check("t1_wr_addr", 32'(wr_addr), 32'h08);
        check("t1_rel_cyc", 32'(rel_cyc - a_cyc), RH + 10);
        check("t1_rst_bad", 32'(rst_bad), 0);
        check("t1_done", 32'(done_cnt - b_done), 1);
        check("t1_err", 32'(err_cnt - b_err), 0);
        check("t1_busy", 32'(busy), 0);

        // 2: read drdy never arrives
        drop_rd = 1;
        snap(); go(7'h10, 16'hFFFF, 16'h0000); wait_ev("t2_wait", 200, 1); settle();
        drop_rd = 0;
        check("t2_err", 32'(err_cnt - b_err), 1);
        check("t2_err_cyc", 32'(err_cyc - rd_cyc), DT);
        check("t2_no_wr", 32'(wr_cnt - b_wr), 0);
        check("t2_done", 32'(done_cnt - b_done), 0);
        check("t2_rst", 32'(mmcm_rst), 0);
        check("t2_busy", 32'(busy), 0);

        // 3: lock never returns
        lock_en = 0;
        snap(); go(7'h0A, 16'h1234, 16'h0000); wait_ev("t3_wait", 300, 1); settle();
        lock_en = 1;
        check("t3_err", 32'(err_cnt - b_err), 1);
        check("t3_err_cyc", 32'(err_cyc - rel_cyc), LT);
        check("t3_wr", 32'(wr_cnt - b_wr), 1);
        check("t3_done", 32'(done_cnt - b_done), 0);

        // 4: reqs during busy and a spurious drdy in idle
        mem[7'h20] = 16'h1234;
        snap(); go(7'h20, 16'h00FF, 16'hFF00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); req = 1; req_addr = 7'h30; req_data = 16'hFFFF; req_mask = 16'h0000;
            @(negedge clk); req = 0;
        end
        wait_ev("t4_wait", 200, 1);
        @(posedge clk); #1 spur_req++;
        settle();
        check("t4_rd", 32'(rd_cnt - b_rd), 1);
        check("t4_wr", 32'(wr_cnt - b_wr), 1);
        check("t4_done", 32'(done_cnt - b_done), 1);
        check("t4_wr_addr", 32'(wr_addr), 32'h20);
        check("t4_wr_di", 32'(wr_di), 32'h12FF);
        check("t4_busy", 32'(busy), 0);

        // 5: async reset in WR_WAIT, then a fresh request
        mem[7'h28] = 16'h7777;
        snap(); go(7'h28, 16'h0000, 16'h00FF);
        for (int i = 0; i < 100 && wr_cnt == b_wr; i++) @(posedge clk);
        check("t5_wr_seen", 32'(wr_cnt - b_wr), 1);
        #1 reset = 1;
        #1 check("t5_rst_outs", {3'b0, busy, done, err, drp_den, drp_dwe, mmcm_rst, drp_daddr, drp_di}, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (6) @(negedge clk);
        check("t5_no_pulse", 32'((done_cnt - b_done) + (err_cnt - b_err)), 0);
        mem[7'h09] = 16'h0F0F;
        snap(); go(7'h09, 16'hABCD, 16'h00FF); wait_ev("t5_wait", 200, 1); settle();
        check("t5_done", 32'(done_cnt - b_done), 1);
        check("t5_wr_di", 32'(wr_di), 32'hAB0F);

        // 6: back-to-back requests
        mem[7'h11] = 16'h5555;
        mem[7'h12] = 16'h00F0;
        snap(); go(7'h11, 16'hAAAA, 16'h0F0F); wait_ev("t6_wait1", 200, 1);
        a1_cyc = done_cyc;
        go(7'h12, 16'h1234, 16'hFF00);
        check("t6_b2b", 32'(a_cyc - a1_cyc), 1);
        wait_ev("t6_wait2", 200, 2); settle();
        check("t6_done", 32'(done_cnt - b_done), 2);
        check("t6_wr", 32'(wr_cnt - b_wr), 2);
        check("t6_rd_lat", 32'(rd_cyc - a_cyc), RH + 1);
        check("t6_rd_addr", 32'(rd_addr), 32'h12);
        check("t6_wr_addr", 32'(wr_addr), 32'h12);
        check("t6_wr_di", 32'(wr_di), 32'h0034);
        check("excl", 32'(both_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
